// File: rtl/mul_round_pack_if.sv
// Valid/ready bus between the normalise stage, the round/pack stage and its consumer.
// slave is the round/pack stage's view; master is the upstream/downstream environment.
interface mul_round_pack_if #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       sign;
    logic [2:0]                 rm;
    logic [EXPO_W+1:0]          expo_2;
    logic [2*MANT_W+1:0]        mant_2;
    logic                       underflow;
    logic                       inexact_sft;
    logic                       bit_s_record;
    logic                       special_vld;
    logic [EXPO_W+MANT_W:0]     special_res;
    logic                       special_nv;
    logic                       out_valid;
    logic                       out_ready;
    logic [EXPO_W+MANT_W:0]     result;
    logic [4:0]                 fflags;

    modport master (
        output in_valid, sign, rm, expo_2, mant_2, underflow, inexact_sft,
               bit_s_record, special_vld, special_res, special_nv, out_ready,
        input  in_ready, out_valid, result, fflags
    );

    modport slave (
        input  in_valid, sign, rm, expo_2, mant_2, underflow, inexact_sft,
               bit_s_record, special_vld, special_res, special_nv, out_ready,
        output in_ready, out_valid, result, fflags
    );
endinterface

// File: rtl/mul_round_pack.sv
// Final FP multiplier stage: IEEE-754 rounding under a dynamic mode, post-round
// carry/overflow/subnormal promotion, then packing of result and exception flags.
module mul_round_pack #(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic            clk,
    input  logic            rst,
    mul_round_pack_if.slave bus
);
    localparam int RES_W = EXPO_W + MANT_W + 1;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EXPO_W+1:0] EXP_SAT = (EXPO_W+2)'((1 << EXPO_W) - 1);

    typedef struct packed {
        logic              sign;
        logic [2:0]        rm;
        logic [EXPO_W+1:0] expo;
        logic [MANT_W+1:0] rounded;
        logic              inexact;
        logic              underflow;
        logic              special_vld;
        logic [RES_W-1:0]  special_res;
        logic              special_nv;
    } s1_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             out_valid_q, out_valid_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [4:0]       fflags_q, fflags_d;
    logic             ready_s1;

    logic [MANT_W:0]  kept;
    logic             lsb, guard, sticky, round_inc;
    logic             unused_mant_msb;

    // Upstream guarantees the bit above the hidden bit is clear.
    assign unused_mant_msb = bus.mant_2[2*MANT_W+1];

    assign ready_s1      = !out_valid_q | bus.out_ready;
    assign bus.in_ready  = !s1_valid_q | ready_s1;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.fflags    = fflags_q;

    always_comb begin
        kept   = bus.mant_2[2*MANT_W:MANT_W];
        lsb    = bus.mant_2[MANT_W];
        guard  = bus.mant_2[MANT_W-1];
        sticky = (|bus.mant_2[MANT_W-2:0]) | bus.bit_s_record;
        case (bus.rm)
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = bus.sign & (guard | sticky);
            RM_RUP:  round_inc = !bus.sign & (guard | sticky);
            RM_RMM:  round_inc = guard;
            default: round_inc = guard & (sticky | lsb);
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (bus.in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.sign        = bus.sign;
                s1_d.rm          = bus.rm;
                s1_d.expo        = bus.expo_2;
                s1_d.rounded     = {1'b0, kept} + (MANT_W+2)'(round_inc);
                s1_d.inexact     = guard | sticky | bus.inexact_sft;
                s1_d.underflow   = bus.underflow;
                s1_d.special_vld = bus.special_vld;
                s1_d.special_res = bus.special_res;
                s1_d.special_nv  = bus.special_nv;
            end
        end
    end

    logic [EXPO_W+1:0] exp_adj;
    logic [MANT_W-1:0] frac_adj;
    logic              overflow, to_inf, uf_flag, nx_flag;
    logic [RES_W-1:0]  pack_res;
    logic [4:0]        pack_flags;

    always_comb begin
        exp_adj  = s1_q.expo;
        frac_adj = s1_q.rounded[MANT_W-1:0];
        // Carry out of the mantissa bumps the exponent; a subnormal that rounds up
        // into the hidden bit becomes the smallest normal.
        if (s1_q.rounded[MANT_W+1]) begin
            exp_adj  = s1_q.expo + (EXPO_W+2)'(1);
            frac_adj = '0;
        end else if (s1_q.expo == '0 && s1_q.rounded[MANT_W]) begin
            exp_adj = (EXPO_W+2)'(1);
        end

        overflow = !s1_q.expo[EXPO_W+1] && (exp_adj >= EXP_SAT);
        case (s1_q.rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_q.sign;
            RM_RUP:  to_inf = !s1_q.sign;
            default: to_inf = 1'b1;
        endcase
        uf_flag = s1_q.underflow & s1_q.inexact;
        nx_flag = s1_q.inexact | overflow;

        if (s1_q.special_vld) begin
            pack_res   = s1_q.special_res;
            pack_flags = {s1_q.special_nv, 4'b0000};
        end else if (overflow) begin
            pack_res   = to_inf ? {s1_q.sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}}
                                : {s1_q.sign, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
            pack_flags = {2'b00, 1'b1, uf_flag, 1'b1};
        end else begin
            pack_res   = {s1_q.sign, exp_adj[EXPO_W-1:0], frac_adj};
            pack_flags = {2'b00, 1'b0, uf_flag, nx_flag};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        fflags_d    = fflags_q;
        if (ready_s1) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = pack_res;
                fflags_d = pack_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            fflags_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            fflags_q    <= fflags_d;
        end
    end
endmodule
